// File: rtl/sd_ctrl_out_pio_if.sv
// Avalon-MM slave bus bundle for sd_ctrl_out_pio: address/select/strobe/write data in, read data out.
interface sd_ctrl_out_pio_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/sd_ctrl_out_pio.sv
// SD side-band control output port: software-written pin value plus a timed XOR pulse.
// Optional OUTSET/OUTCLR registers at addresses 4/5 under macro SD_CTRL_OUT_PIO_BITSET_EN.
module sd_ctrl_out_pio #(
  parameter int unsigned      WIDTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int unsigned      LEN_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  sd_ctrl_out_pio_if.slave   bus,
  output logic [WIDTH-1:0]   out_port
);

  typedef enum logic {StIdle, StPulse} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [WIDTH-1:0]   mask_q, mask_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        rdata_d;
  logic [WIDTH-1:0]   wd_mask;
  logic [15:0]        cnt_ext;
  logic               wr;
  logic               unused_wd;

  assign wr        = bus.chipselect & ~bus.write_n;
  assign wd_mask   = bus.writedata[WIDTH-1:0];
  assign cnt_ext   = 16'(cnt_q);
  assign unused_wd = ^bus.writedata;

  // Register writes
  always_comb begin
    data_d = data_q;
    len_d  = len_q;
    if (wr) begin
      unique case (bus.address)
        3'd0: data_d = wd_mask;
        3'd1: len_d  = bus.writedata[LEN_W-1:0];
`ifdef SD_CTRL_OUT_PIO_BITSET_EN
        3'd4: data_d = data_q | wd_mask;
        3'd5: data_d = data_q & ~wd_mask;
`endif
        default: ;
      endcase
    end
  end

  // Pulse FSM; GO writes while busy are dropped
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (wr && bus.address == 3'd2 && len_q != '0 && wd_mask != '0) begin
          state_d = StPulse;
          mask_d  = wd_mask;
          cnt_d   = len_q;
        end
      end
      StPulse: begin
        if (cnt_q == LEN_W'(1)) begin
          state_d = StIdle;
          mask_d  = '0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - LEN_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rdata_d = '0;
    unique case (bus.address)
      3'd0:    rdata_d = 32'(data_q);
      3'd1:    rdata_d = 32'(len_q);
      3'd2:    rdata_d = {cnt_ext, 15'b0, state_q == StPulse};
      3'd3:    rdata_d = 32'(mask_q);
      default: rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      data_q       <= RESET_VALUE;
      mask_q       <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
      bus.readdata <= '0;
      out_port     <= RESET_VALUE;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      mask_q       <= mask_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      bus.readdata <= rdata_d;
      out_port     <= data_d ^ ((state_d == StPulse) ? mask_d : '0);
    end
  end

endmodule

// File: tb/tb_sd_ctrl_out_pio.sv
// Directed self-checking bench for sd_ctrl_out_pio (WIDTH=4, RESET_VALUE=4'h5, LEN_W=16).
module tb_sd_ctrl_out_pio;
  logic       clk;
  logic       rst;
  logic [3:0] out_port;
  int         nvec;
  int         nerr;

  sd_ctrl_out_pio_if bus ();

  sd_ctrl_out_pio #(
    .WIDTH       (4),
    .RESET_VALUE (4'h5),
    .LEN_W       (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .out_port (out_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One write cycle; returns 1ns after the edge that samples it
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(posedge clk);
    #1;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    rst            = 1'b1;
    bus.address    = 3'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
    #22;
    check("reset_out", 32'(out_port), 32'h5);
    check("reset_rd", bus.readdata, 32'h0);
    rst = 1'b0;
    tick();

    // DATA write and read-back
    wr(3'd0, 32'hFFFF_FFFA);
    check("data_out", 32'(out_port), 32'hA);
    tick();
    check("data_rd", bus.readdata, 32'hA);

    // LEN=3 pulse, mask 1
    wr(3'd1, 32'd3);
    tick();
    check("len_rd", bus.readdata, 32'd3);
    wr(3'd0, 32'h0);
    wr(3'd2, 32'h1);
    check("p3_e0", 32'(out_port), 32'h1);
    tick();
    check("p3_e1", 32'(out_port), 32'h1);
    check("p3_busy3", bus.readdata, 32'h0003_0001);
    tick();
    check("p3_e2", 32'(out_port), 32'h1);
    check("p3_busy2", bus.readdata, 32'h0002_0001);
    tick();
    check("p3_end", 32'(out_port), 32'h0);
    check("p3_busy1", bus.readdata, 32'h0001_0001);
    tick();
    check("p3_idle_rd", bus.readdata, 32'h0);

    // GO while busy ignored
    wr(3'd1, 32'd5);
    wr(3'd2, 32'h1);
    wr(3'd2, 32'h2);
    bus.address = 3'd3;
    tick();
    check("busy_go_mask", bus.readdata, 32'h1);
    check("busy_go_out", 32'(out_port), 32'h1);
    tick();
    check("p5_e3", 32'(out_port), 32'h1);
    tick();
    check("p5_e4", 32'(out_port), 32'h1);
    tick();
    check("p5_end", 32'(out_port), 32'h0);
    tick();
    check("p5_mask_clr", bus.readdata, 32'h0);

    // GO with LEN=0 does nothing
    wr(3'd1, 32'd0);
    wr(3'd2, 32'hF);
    check("len0_out", 32'(out_port), 32'h0);
    tick();
    check("len0_busy", bus.readdata, 32'h0);

    // DATA write mid-pulse
    wr(3'd1, 32'd4);
    wr(3'd2, 32'h1);
    wr(3'd0, 32'h8);
    check("mid_e1", 32'(out_port), 32'h9);
    tick();
    check("mid_e2", 32'(out_port), 32'h9);
    tick();
    check("mid_e3", 32'(out_port), 32'h9);
    tick();
    check("mid_end", 32'(out_port), 32'h8);

    // OUTSET / OUTCLR
    wr(3'd0, 32'h3);
    wr(3'd4, 32'h8);
    wr(3'd5, 32'h1);
    bus.address = 3'd0;
    tick();
`ifdef SD_CTRL_OUT_PIO_BITSET_EN
    check("bitset_rd", bus.readdata, 32'hA);
    check("bitset_out", 32'(out_port), 32'hA);
`else
    check("bitset_rd", bus.readdata, 32'h3);
    check("bitset_out", 32'(out_port), 32'h3);
`endif
    bus.address = 3'd4;
    tick();
    check("addr4_rd", bus.readdata, 32'h0);
    bus.address = 3'd7;
    tick();
    check("addr7_rd", bus.readdata, 32'h0);

    // Reset mid-pulse
    wr(3'd0, 32'h0);
    wr(3'd1, 32'd5);
    wr(3'd2, 32'h2);
    check("pre_rst_out", 32'(out_port), 32'h2);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_out", 32'(out_port), 32'h5);
    check("rst_mid_rd", bus.readdata, 32'h0);
    #3 rst = 1'b0;
    bus.address = 3'd2;
    tick();
    check("post_rst_busy", bus.readdata, 32'h0);
    check("post_rst_out", 32'(out_port), 32'h5);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
